// File: rtl/muldiv_unit_pkg.sv
// Shared opcode constants and helpers for the multiply/divide unit.
// The alucontrol opcode values are the same ones the decoder emits, so
// every consumer takes them from here rather than keeping local copies.
package muldiv_unit_pkg;

  localparam logic [7:0] MULT_OP  = 8'h18;
  localparam logic [7:0] MULTU_OP = 8'h19;
  localparam logic [7:0] DIV_OP   = 8'h1a;
  localparam logic [7:0] DIVU_OP  = 8'h1b;

  // Two's-complement magnitude. The most negative value maps to 32'h8000_0000,
  // which is correct when the result is read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Radix-2 restoring divider datapath (div_iter).
// It produces one quotient bit per enabled cycle, MSB first. The dividend is
// shifted out of the quotient register while quotient bits shift in.
// Ports:
//   clk, resetn    clock, async active-low reset
//   load_i         clear partial remainder, load dividend into quotient register
//   step_i         perform one restoring iteration
//   dividend_i     unsigned dividend (sampled on load_i)
//   divisor_i      unsigned divisor (held stable by the owner while stepping)
//   quot_next_o    quotient register value after the current step
//   rem_next_o     remainder value after the current step
module muldiv_unit_div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_next_o,
  output logic [31:0] rem_next_o
);

  logic [32:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [33:0] shifted;
  logic [33:0] diff;
  logic        ge;

  always_comb begin
    // The top bit of the shifted remainder is always zero; keeping it makes the
    // borrow of the trial subtraction land in diff[33].
    shifted = {rem_q, quot_q[31]};
    diff    = shifted - {2'b00, divisor_i};
    ge      = ~diff[33];
    rem_d   = ge ? diff[32:0] : shifted[32:0];
    quot_d  = {quot_q[30:0], ge};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quot_q <= '0;
    end else if (load_i) begin
      rem_q  <= '0;
      quot_q <= dividend_i;
    end else if (step_i) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign quot_next_o = quot_d;
  assign rem_next_o  = rem_d[31:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// It accepts MULT/MULTU/DIV/DIVU, stalls the pipeline while busy, and
// produces {hi, lo} with a one-cycle result_valid_o pulse.
// Ports:
//   clk, resetn        clock, async active-low reset
//   valid_i            EX-stage instruction valid
//   alucontrol_i       8-bit operation code
//   a_i, b_i           rs / rt operand values
//   flush_i            abort any in-flight operation
//   stall_o            hold the pipeline while an accepted op is unfinished
//   result_valid_o     high for the single DONE cycle
//   hi_o, lo_o         remainder/upper product, quotient/lower product
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [7:0]  alucontrol_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        result_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, b_q, a_raw_q;
  logic        neg_quo_q, neg_rem_q;

  logic        is_mul, is_signed, is_muldiv, start, accept;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod, prod_fix;
  logic [31:0] quot_next, rem_next, quot_fix, rem_fix;

  assign is_mul    = (alucontrol_i == MULT_OP) || (alucontrol_i == MULTU_OP);
  assign is_signed = (alucontrol_i == MULT_OP) || (alucontrol_i == DIV_OP);
  assign is_muldiv = is_mul || (alucontrol_i == DIV_OP) || (alucontrol_i == DIVU_OP);
  assign start     = valid_i & ~flush_i & is_muldiv;
  // The stalled instruction keeps presenting start while busy; only a start seen
  // in IDLE or DONE begins a new operation.
  assign accept    = start & ((state_q == StIdle) || (state_q == StDone));

  assign a_mag = is_signed ? abs32(a_i) : a_i;
  assign b_mag = is_signed ? abs32(b_i) : b_i;

  assign prod     = {32'd0, a_q} * {32'd0, b_q};
  assign prod_fix = neg_quo_q ? (~prod + 64'd1) : prod;
  assign quot_fix = neg_quo_q ? (~quot_next + 32'd1) : quot_next;
  assign rem_fix  = neg_rem_q ? (~rem_next + 32'd1) : rem_next;

  muldiv_unit_div_iter u_div_iter (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (accept),
    .step_i      (state_q == StDiv),
    .dividend_i  (a_mag),
    .divisor_i   (b_q),
    .quot_next_o (quot_next),
    .rem_next_o  (rem_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = is_mul ? StMul : StDiv;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StMul: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          state_d      = StDone;
          {hi_d, lo_d} = prod_fix;
        end
      end
      StDiv: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (cnt_q == 6'd31) begin
          state_d = StDone;
          if (b_q == '0) begin
            // Divide by zero: fixed pattern, no sign correction.
            hi_d = a_raw_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (accept) begin
        a_q       <= a_mag;
        b_q       <= b_mag;
        a_raw_q   <= a_i;
        neg_quo_q <= is_signed & (a_i[31] ^ b_i[31]);
        neg_rem_q <= is_signed & a_i[31];
      end
    end
  end

  assign stall_o        = start | (state_q == StMul) | (state_q == StDiv);
  assign result_valid_o = (state_q == StDone);
  assign hi_o           = hi_q;
  assign lo_o           = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, flush/reset scenarios
// and randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i;
  logic [7:0]  alucontrol_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        result_valid_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int          nvec = 0;
  int          nerr = 0;
  logic [63:0] last;  // {hi, lo} the DUT should currently hold

  muldiv_unit dut (
    .clk            (clk),
    .resetn         (resetn),
    .valid_i        (valid_i),
    .alucontrol_i   (alucontrol_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .hi_o           (hi_o),
    .lo_o           (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == MULT_OP) return 64'(sa * sb);
    if (op == MULTU_OP) return ua * ub;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == DIV_OP) begin
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return {r[31:0], q[31:0]};
  endfunction

  function automatic bit is_op(input logic [7:0] op);
    return (op == MULT_OP) || (op == MULTU_OP) || (op == DIV_OP) || (op == DIVU_OP);
  endfunction

  // Issue one op in the current cycle (cycle 0), scramble inputs afterwards,
  // and check latency, stall length and the result.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit flush_done);
    logic [63:0] expv;
    int          lat, cyc, stalls;
    bit          seen;
    expv = model(op, a, b);
    lat  = ((op == MULT_OP) || (op == MULTU_OP)) ? 2 : 33;
    valid_i = 1'b1; alucontrol_i = op; a_i = a; b_i = b; flush_i = 1'b0;
    #1;
    stalls = stall_o ? 1 : 0;
    seen   = 1'b0;
    cyc    = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      valid_i = 1'b0; alucontrol_i = 8'($urandom); a_i = $urandom; b_i = $urandom;
      flush_i = (cyc == lat) ? flush_done : 1'b0;
      #1;
      if (stall_o) stalls++;
      if (result_valid_o) seen = 1'b1;
      else check("hold_busy", {hi_o, lo_o}, last);
    end
    check("latency", 64'(cyc), 64'(lat));
    check("stall_cycles", 64'(stalls), 64'(lat));
    check("hilo", {hi_o, lo_o}, expv);
    last = expv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_i = 1'b0; flush_i = 1'b0; alucontrol_i = 8'($urandom);
      a_i = $urandom; b_i = $urandom;
      #1;
      check("idle_stall", 64'(stall_o), 64'd0);
      check("idle_pulse", 64'(result_valid_o), 64'd0);
      check("idle_hold", {hi_o, lo_o}, last);
    end
  endtask

  initial begin
    logic [7:0]  ops [4];
    logic [7:0]  op;
    logic [31:0] a, b;
    ops = '{MULT_OP, MULTU_OP, DIV_OP, DIVU_OP};

    resetn = 1'b0; valid_i = 1'b0; flush_i = 1'b0; alucontrol_i = '0;
    a_i = '0; b_i = '0; last = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_pulse", 64'(result_valid_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    idle(1);

    // Directed cases, some back-to-back through DONE.
    run_op(MULT_OP, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(1);
    run_op(MULTU_OP, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(DIV_OP, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(DIVU_OP, 32'd7, 32'd2, 1'b0);
    run_op(DIVU_OP, 32'd100, 32'd0, 1'b0);
    run_op(DIV_OP, 32'hFFFF_FFF9, 32'd0, 1'b1);
    idle(1);
    run_op(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(2);

    // Flush at DIV cycle 10: no pulse, hi/lo hold, then a normal MULT.
    @(negedge clk);
    valid_i = 1'b1; alucontrol_i = DIV_OP; a_i = $urandom; b_i = $urandom | 32'd1;
    flush_i = 1'b0;
    repeat (10) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    flush_i = 1'b1;
    #1;
    check("flush_div_stall", 64'(stall_o), 64'd1);
    idle(30);
    run_op(MULT_OP, 32'h1234_5678, 32'hFEDC_BA98, 1'b0);
    idle(1);

    // Flush together with a start: nothing accepted.
    @(negedge clk);
    valid_i = 1'b1; alucontrol_i = MULT_OP; a_i = 32'd3; b_i = 32'd5; flush_i = 1'b1;
    #1;
    check("flush_start_stall", 64'(stall_o), 64'd0);
    idle(3);

    // Reset at DIV cycle 20.
    @(negedge clk);
    valid_i = 1'b1; alucontrol_i = DIVU_OP; a_i = 32'hDEAD_BEEF; b_i = 32'd3;
    repeat (20) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
    resetn = 1'b0;
    #1;
    last = '0;
    check("midrst_hilo", {hi_o, lo_o}, 64'd0);
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_pulse", 64'(result_valid_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    idle(35);

    // Non-mult/div opcode with valid high.
    do op = 8'($urandom); while (is_op(op));
    @(negedge clk);
    valid_i = 1'b1; alucontrol_i = op; a_i = $urandom; b_i = $urandom; flush_i = 1'b0;
    #1;
    check("nonop_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    #1;
    check("nonop_stall2", 64'(stall_o), 64'd0);
    check("nonop_pulse", 64'(result_valid_o), 64'd0);
    idle(2);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
